// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio capture/playback path.
package audio_pkg;

  localparam int SAMPLE_BITS_DEFAULT = 16;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchroniser for a slow asynchronous level, plus a history flop for edge detection.
// toggle pulses for one clk on either edge; rise = toggle & level, fall = toggle & ~level.
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic toggle
);

  logic [STAGES-1:0] sync_reg;
  logic              hist_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      hist_reg <= sync_reg[STAGES-1];
    end
  end

  assign level  = sync_reg[STAGES-1];
  assign toggle = level ^ hist_reg;

endmodule

// File: rtl/i2s_receiver.sv
// I2S record-path deserialiser: oversamples bclk/reclrc/recdat in the mclk domain
// and presents each complete left/right pair on a valid/ready handshake.
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
  parameter int SLOT_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic                          audio_I2S_bclk,
  input  logic                          audio_I2S_reclrc,
  input  logic                          audio_I2S_recdat,
  output logic signed [SAMPLE_BITS-1:0] left_sample,
  output logic signed [SAMPLE_BITS-1:0] right_sample,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          overrun,
  output logic                          frame_error
);

  localparam int CNT_W = $clog2(SLOT_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_BITS + 1);

  logic bclk_level, bclk_toggle, bclk_rise;
  logic lrc_level, lrc_toggle;
  logic [SYNC_STAGES-1:0] dat_sync_reg;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk    (mclk),
    .rst    (rst),
    .din    (audio_I2S_bclk),
    .level  (bclk_level),
    .toggle (bclk_toggle)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_lrc_sync (
    .clk    (mclk),
    .rst    (rst),
    .din    (audio_I2S_reclrc),
    .level  (lrc_level),
    .toggle (lrc_toggle)
  );

  // Data only needs the same latency as bclk so it lines up with the detected rise.
  always_ff @(posedge mclk) begin
    if (rst) begin
      dat_sync_reg <= '0;
    end else begin
      dat_sync_reg[0] <= audio_I2S_recdat;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dat_sync_reg[i] <= dat_sync_reg[i-1];
      end
    end
  end

  assign bclk_rise = bclk_toggle & bclk_level;

  i2s_rx_state_e                 state_reg, state_next;
  logic [CNT_W-1:0]              bit_cnt_reg, bit_cnt_next, bit_cnt_inc;
  logic [SLOT_BITS-2:0]          shift_reg, shift_next;
  logic [SLOT_BITS-1:0]          shift_cap;
  logic signed [SAMPLE_BITS-1:0] word;
  logic signed [SAMPLE_BITS-1:0] left_hold_reg, left_hold_next;
  logic signed [SAMPLE_BITS-1:0] left_sample_reg, left_sample_next;
  logic signed [SAMPLE_BITS-1:0] right_sample_reg, right_sample_next;
  logic valid_reg, valid_next;
  logic overrun_reg, overrun_next;
  logic frame_error_reg, frame_error_next;
  logic lrc_flip_reg, lrc_flip_next;
  logic transition, slot_ok, pair_done;

  // Parity of lrc edges since the last bclk rise == "lrc differs from its value at that rise".
  assign transition  = lrc_flip_reg ^ lrc_toggle;
  assign shift_cap   = {shift_reg, dat_sync_reg[SYNC_STAGES-1]};
  assign word        = shift_cap[SLOT_BITS-1 -: SAMPLE_BITS];
  assign bit_cnt_inc = (bit_cnt_reg == CNT_MAX) ? bit_cnt_reg : bit_cnt_reg + 1'b1;
  assign slot_ok     = (bit_cnt_inc == CNT_SLOT);

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_reg        <= SYNC;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      left_hold_reg    <= '0;
      left_sample_reg  <= '0;
      right_sample_reg <= '0;
      valid_reg        <= 1'b0;
      overrun_reg      <= 1'b0;
      frame_error_reg  <= 1'b0;
      lrc_flip_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      shift_reg        <= shift_next;
      left_hold_reg    <= left_hold_next;
      left_sample_reg  <= left_sample_next;
      right_sample_reg <= right_sample_next;
      valid_reg        <= valid_next;
      overrun_reg      <= overrun_next;
      frame_error_reg  <= frame_error_next;
      lrc_flip_reg     <= lrc_flip_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    shift_next        = shift_reg;
    left_hold_next    = left_hold_reg;
    left_sample_next  = left_sample_reg;
    right_sample_next = right_sample_reg;
    valid_next        = valid_reg;
    overrun_next      = overrun_reg;
    frame_error_next  = 1'b0;
    lrc_flip_next     = lrc_flip_reg ^ lrc_toggle;
    pair_done         = 1'b0;

    if (valid_reg && sample_ready) begin
      valid_next = 1'b0;
    end

    if (bclk_rise) begin
      lrc_flip_next = 1'b0;
      shift_next    = shift_cap[SLOT_BITS-2:0];
      bit_cnt_next  = bit_cnt_inc;
      // The bit captured on a transition rise is the LSB of the slot just ending.
      if (transition) begin
        bit_cnt_next = '0;
        case (state_reg)
          SYNC: begin
            if (!lrc_level) begin
              state_next = LEFT;
            end
          end
          LEFT: begin
            if (lrc_level && slot_ok) begin
              left_hold_next = word;
              state_next     = RIGHT;
            end else begin
              frame_error_next = 1'b1;
              state_next       = SYNC;
            end
          end
          RIGHT: begin
            if (!lrc_level && slot_ok) begin
              pair_done  = 1'b1;
              state_next = LEFT;
            end else begin
              frame_error_next = 1'b1;
              state_next       = SYNC;
            end
          end
          default: state_next = SYNC;
        endcase
      end
    end

    if (pair_done) begin
      if (!valid_reg || sample_ready) begin
        left_sample_next  = left_hold_reg;
        right_sample_next = word;
        valid_next        = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  assign left_sample  = left_sample_reg;
  assign right_sample = right_sample_reg;
  assign sample_valid = valid_reg;
  assign overrun      = overrun_reg;
  assign frame_error  = frame_error_reg;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: bclk = mclk/16, I2S frames built bit by bit with the one-bit delay.
module tb_i2s_receiver;

  logic mclk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b0;
  logic lrc = 1'b0;
  logic dat = 1'b0;
  logic ready = 1'b0;
  logic carry = 1'b0;

  logic signed [15:0] left16, right16, left32, right32;
  logic valid16, overrun16, ferr16, valid32, overrun32, ferr32;

  int n_vec = 0;
  int n_err = 0;

  int xfer_cnt = 0;
  int fe_cnt = 0;
  logic [15:0] xfer_l = 16'h0;
  logic [15:0] xfer_r = 16'h0;

  always #5 mclk = ~mclk;

  i2s_receiver #(.SAMPLE_BITS(16), .SLOT_BITS(16), .SYNC_STAGES(2)) dut (
    .mclk             (mclk),
    .rst              (rst),
    .audio_I2S_bclk   (bclk),
    .audio_I2S_reclrc (lrc),
    .audio_I2S_recdat (dat),
    .left_sample      (left16),
    .right_sample     (right16),
    .sample_valid     (valid16),
    .sample_ready     (ready),
    .overrun          (overrun16),
    .frame_error      (ferr16)
  );

  i2s_receiver #(.SAMPLE_BITS(16), .SLOT_BITS(32), .SYNC_STAGES(2)) dut32 (
    .mclk             (mclk),
    .rst              (rst),
    .audio_I2S_bclk   (bclk),
    .audio_I2S_reclrc (lrc),
    .audio_I2S_recdat (dat),
    .left_sample      (left32),
    .right_sample     (right32),
    .sample_valid     (valid32),
    .sample_ready     (ready),
    .overrun          (overrun32),
    .frame_error      (ferr32)
  );

  // Transfer / frame-error monitor on the 16-bit instance
  always @(posedge mclk) begin
    if (valid16 && ready) begin
      xfer_cnt <= xfer_cnt + 1;
      xfer_l   <= left16;
      xfer_r   <= right16;
      $display("xfer left=%h right=%h t=%0t", left16, right16, $time);
    end
    if (ferr16) fe_cnt <= fe_cnt + 1;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic send_bit(input logic l, input logic d);
    bclk = 1'b0; lrc = l; dat = d;
    wait_neg(8);
    bclk = 1'b1;
    wait_neg(8);
  endtask

  // First rise of a slot carries the previous slot's LSB.
  task automatic send_slot(input logic l, input logic [31:0] w, input int bits);
    for (int i = 0; i < bits; i++) send_bit(l, (i == 0) ? carry : w[bits-i]);
    carry = w[0];
  endtask

  task automatic apply_reset();
    rst = 1'b1; ready = 1'b0; bclk = 1'b0; lrc = 1'b0; dat = 1'b0; carry = 1'b0;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({left16, right16, valid16, overrun16, ferr16} !== 35'd0) begin
      n_err++;
      $display("FAIL reset16: got %h required 0", {left16, right16, valid16, overrun16, ferr16});
    end
    n_vec++;
    if ({left32, right32, valid32, overrun32, ferr32} !== 35'd0) begin
      n_err++;
      $display("FAIL reset32: got %h required 0", {left32, right32, valid32, overrun32, ferr32});
    end
  endtask

  task automatic test_nominal();
    int lat;
    int base_x;
    int base_fe;
    apply_reset();
    ready = 1'b1;
    base_x = xfer_cnt; base_fe = fe_cnt;
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, 32'h1234, 16);
    send_slot(1'b1, 32'hABCD, 16);
    bclk = 1'b0; lrc = 1'b0; dat = carry;
    wait_neg(8);
    bclk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      wait_neg(1);
      if (valid16) lat = k;
    end
    n_vec++;
    if (lat < 3 || lat > 4) begin
      n_err++;
      $display("FAIL nominal_latency: got %0d mclk required 3..4", lat);
    end
    n_vec++;
    if (left16 !== 16'h1234) begin
      n_err++;
      $display("FAIL nominal_left: got %h required 1234", left16);
    end
    n_vec++;
    if (right16 !== 16'hABCD) begin
      n_err++;
      $display("FAIL nominal_right: got %h required abcd", right16);
    end
    wait_neg(1);
    n_vec++;
    if (valid16 !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_pulse: valid got %b required 0", valid16);
    end
    n_vec++;
    if (xfer_cnt - base_x != 1 || fe_cnt != base_fe) begin
      n_err++;
      $display("FAIL nominal_count: xfers %0d ferr %0d required 1 0", xfer_cnt - base_x, fe_cnt - base_fe);
    end
  endtask

  task automatic test_sign32();
    apply_reset();
    send_slot(1'b1, 32'h0, 32);
    send_slot(1'b0, 32'h8000_FFFF, 32);
    send_slot(1'b1, 32'h7FFF_0001, 32);
    send_bit(1'b0, carry);
    n_vec++;
    if (valid32 !== 1'b1 || left32 !== 16'h8000) begin
      n_err++;
      $display("FAIL sign_left: valid %b left %h required 1 8000", valid32, left32);
    end
    n_vec++;
    if (right32 !== 16'h7FFF) begin
      n_err++;
      $display("FAIL sign_right: got %h required 7fff", right32);
    end
  endtask

  task automatic test_backpressure();
    int base_x;
    apply_reset();
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, 32'h0001, 16);
    send_slot(1'b1, 32'h0002, 16);
    send_slot(1'b0, 32'h0003, 16);
    send_slot(1'b1, 32'h0004, 16);
    send_bit(1'b0, carry);
    n_vec++;
    if (valid16 !== 1'b1 || left16 !== 16'h0001 || right16 !== 16'h0002) begin
      n_err++;
      $display("FAIL bp_hold: valid %b left %h right %h required 1 0001 0002", valid16, left16, right16);
    end
    n_vec++;
    if (overrun16 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_overrun: got %b required 1", overrun16);
    end
    base_x = xfer_cnt;
    ready = 1'b1;
    wait_neg(1);
    ready = 1'b0;
    n_vec++;
    if (valid16 !== 1'b0 || overrun16 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept: valid %b overrun %b required 0 1", valid16, overrun16);
    end
    n_vec++;
    if (xfer_cnt - base_x != 1 || xfer_l !== 16'h0001 || xfer_r !== 16'h0002) begin
      n_err++;
      $display("FAIL bp_xfer: n %0d left %h right %h required 1 0001 0002", xfer_cnt - base_x, xfer_l, xfer_r);
    end
  endtask

  task automatic test_back_to_back();
    int base_x;
    apply_reset();
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, 32'h0A0A, 16);
    send_slot(1'b1, 32'h0B0B, 16);
    send_slot(1'b0, 32'h0C0C, 16);
    send_slot(1'b1, 32'h0D0D, 16);
    base_x = xfer_cnt;
    bclk = 1'b0; lrc = 1'b0; dat = carry;
    wait_neg(8);
    bclk = 1'b1;
    wait_neg(2);
    ready = 1'b1;
    wait_neg(1);
    ready = 1'b0;
    n_vec++;
    if (valid16 !== 1'b1 || left16 !== 16'h0C0C || right16 !== 16'h0D0D) begin
      n_err++;
      $display("FAIL b2b_load: valid %b left %h right %h required 1 0c0c 0d0d", valid16, left16, right16);
    end
    n_vec++;
    if (overrun16 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_overrun: got %b required 0", overrun16);
    end
    n_vec++;
    if (xfer_cnt - base_x != 1 || xfer_l !== 16'h0A0A || xfer_r !== 16'h0B0B) begin
      n_err++;
      $display("FAIL b2b_xfer: n %0d left %h right %h required 1 0a0a 0b0b", xfer_cnt - base_x, xfer_l, xfer_r);
    end
    wait_neg(6);
  endtask

  task automatic test_frame_error();
    int base_x;
    int base_fe;
    apply_reset();
    ready = 1'b1;
    base_x = xfer_cnt; base_fe = fe_cnt;
    send_slot(1'b1, 32'h0, 16);
    for (int i = 0; i < 12; i++) send_bit(1'b0, (i == 0) ? carry : 1'b1);
    send_slot(1'b1, 32'h0, 16);
    n_vec++;
    if (fe_cnt - base_fe != 1 || xfer_cnt != base_x) begin
      n_err++;
      $display("FAIL ferr_pulse: pulses %0d xfers %0d required 1 0", fe_cnt - base_fe, xfer_cnt - base_x);
    end
    send_slot(1'b0, 32'h5555, 16);
    send_slot(1'b1, 32'hAAAA, 16);
    send_bit(1'b0, carry);
    n_vec++;
    if (xfer_cnt - base_x != 1 || xfer_l !== 16'h5555 || xfer_r !== 16'hAAAA) begin
      n_err++;
      $display("FAIL ferr_resync: n %0d left %h right %h required 1 5555 aaaa", xfer_cnt - base_x, xfer_l, xfer_r);
    end
    n_vec++;
    if (fe_cnt - base_fe != 1) begin
      n_err++;
      $display("FAIL ferr_total: got %0d pulses required 1", fe_cnt - base_fe);
    end
  endtask

  task automatic test_reset_midword();
    int base_x;
    int base_fe;
    logic [15:0] w3;
    apply_reset();
    w3 = 16'h3333;
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, 32'h1111, 16);
    send_slot(1'b1, 32'h2222, 16);
    for (int i = 0; i < 7; i++) send_bit(1'b0, (i == 0) ? carry : w3[16-i]);
    n_vec++;
    if (valid16 !== 1'b1 || left16 !== 16'h1111 || right16 !== 16'h2222) begin
      n_err++;
      $display("FAIL midrst_pre: valid %b left %h right %h required 1 1111 2222", valid16, left16, right16);
    end
    rst = 1'b1;
    wait_neg(1);
    rst = 1'b0;
    n_vec++;
    if ({left16, right16, valid16, overrun16, ferr16} !== 35'd0) begin
      n_err++;
      $display("FAIL midrst_zero: got %h required 0", {left16, right16, valid16, overrun16, ferr16});
    end
    ready = 1'b1;
    base_x = xfer_cnt; base_fe = fe_cnt;
    for (int i = 7; i < 16; i++) send_bit(1'b0, w3[16-i]);
    carry = w3[0];
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, 32'h0F0F, 16);
    send_slot(1'b1, 32'hF0F0, 16);
    send_bit(1'b0, carry);
    n_vec++;
    if (xfer_cnt - base_x != 1 || xfer_l !== 16'h0F0F || xfer_r !== 16'hF0F0) begin
      n_err++;
      $display("FAIL midrst_next: n %0d left %h right %h required 1 0f0f f0f0", xfer_cnt - base_x, xfer_l, xfer_r);
    end
    n_vec++;
    if (fe_cnt != base_fe) begin
      n_err++;
      $display("FAIL midrst_ferr: got %0d pulses required 0", fe_cnt - base_fe);
    end
  endtask

  initial begin
    wait_neg(1);
    test_reset();
    test_nominal();
    test_backpressure();
    test_back_to_back();
    test_frame_error();
    test_reset_midword();
    test_sign32();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
